latch_bank_acc: RTL and testbench

- Parametrised successor to the team's fixed dual 4-bit input latch: NUM_CH channel registers of DATA_W bits each, written from a shared data bus.
- Each write either loads the value or accumulates it into the selected channel, with per-channel sticky overflow flags.
- A snapshot/dump sequencer streams all channel values out over a valid/ready handshake to the downstream UART transmit path.

---
 rtl/latch_bank_acc.sv | 137 +++++++++++++
 tb/tb_latch_bank_acc.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/latch_bank_acc.sv
// Bank of NUM_CH load/accumulate channel registers with sticky overflow flags,
// plus a snapshot sequencer that streams every channel out over valid/ready.
module latch_bank_acc #(
    parameter int DATA_W   = 4,
    parameter int NUM_CH   = 2,
    parameter bit SATURATE = 1'b0,
    localparam int CW      = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_W-1:0]        data_in,
    input  logic [CW-1:0]            ch_sel,
    input  logic                     wr_en,
    input  logic                     acc_mode,
    input  logic                     clear_all,
    output logic [NUM_CH*DATA_W-1:0] q_flat,
    output logic [NUM_CH-1:0]        ovf,
    input  logic                     dump_start,
    output logic                     dump_busy,
    output logic                     dump_valid,
    input  logic                     dump_ready,
    output logic [DATA_W-1:0]        dump_data,
    output logic [CW-1:0]            dump_ch
);

    typedef enum logic {IDLE, SEND} state_e;

    logic [DATA_W-1:0] ch_q [NUM_CH];
    logic [DATA_W-1:0] ch_d [NUM_CH];
    logic [NUM_CH-1:0] ovf_q, ovf_d;
    logic [DATA_W:0]   sum;

    state_e            state_q;
    logic [CW-1:0]     idx_q;
    logic [DATA_W-1:0] snap_q [NUM_CH];
    logic              dump_valid_q, dump_busy_q;
    logic [DATA_W-1:0] dump_data_q;

    // Returns {carry, result}; the result is clamped when saturation is enabled.
    function automatic logic [DATA_W:0] acc_step(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        logic [DATA_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (SATURATE && s[DATA_W])
            s[DATA_W-1:0] = '1;
        return s;
    endfunction

    always_comb begin
        ch_d  = ch_q;
        ovf_d = ovf_q;
        sum   = '0;
        if (clear_all) begin
            for (int i = 0; i < NUM_CH; i++)
                ch_d[i] = '0;
            ovf_d = '0;
        end else if (wr_en) begin
            // Out-of-range ch_sel matches no channel, so the write is dropped.
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_sel == CW'(i)) begin
                    if (acc_mode) begin
                        sum     = acc_step(ch_q[i], data_in);
                        ch_d[i] = sum[DATA_W-1:0];
                        if (sum[DATA_W])
                            ovf_d[i] = 1'b1;
                    end else begin
                        ch_d[i] = data_in;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++)
                ch_q[i] <= '0;
            ovf_q <= '0;
        end else begin
            ch_q  <= ch_d;
            ovf_q <= ovf_d;
        end
    end

    // Snapshot takes the pre-edge channel values, so a same-cycle write is excluded.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            dump_valid_q <= 1'b0;
            dump_busy_q  <= 1'b0;
            dump_data_q  <= '0;
            for (int i = 0; i < NUM_CH; i++)
                snap_q[i] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (dump_start) begin
                        snap_q       <= ch_q;
                        idx_q        <= '0;
                        dump_data_q  <= ch_q[0];
                        dump_valid_q <= 1'b1;
                        dump_busy_q  <= 1'b1;
                        state_q      <= SEND;
                    end
                end
                SEND: begin
                    if (dump_ready) begin
                        if (idx_q == CW'(NUM_CH - 1)) begin
                            idx_q        <= '0;
                            dump_valid_q <= 1'b0;
                            dump_busy_q  <= 1'b0;
                            state_q      <= IDLE;
                        end else begin
                            idx_q       <= idx_q + 1'b1;
                            dump_data_q <= snap_q[idx_q + 1'b1];
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        q_flat = '0;
        for (int i = 0; i < NUM_CH; i++)
            q_flat[i*DATA_W +: DATA_W] = ch_q[i];
    end

    assign ovf        = ovf_q;
    assign dump_busy  = dump_busy_q;
    assign dump_valid = dump_valid_q;
    assign dump_data  = dump_data_q;
    assign dump_ch    = idx_q;

endmodule

// File: tb/tb_latch_bank_acc.sv
// Bench for latch_bank_acc: a wrap and a saturate instance (3 channels each)
// share one stimulus stream and are compared every cycle to a queue-based model.
module tb_latch_bank_acc;

    localparam int DW = 4;
    localparam int NC = 3;

    logic          clk = 1'b0;
    logic          reset, wr_en, acc_mode, clear_all, dump_start, dump_ready;
    logic [DW-1:0] data_in;
    logic [1:0]    ch_sel;

    logic [NC*DW-1:0] qf  [2];
    logic [NC-1:0]    ov  [2];
    logic             bsy [2];
    logic             vld [2];
    logic [DW-1:0]    dd  [2];
    logic [1:0]       dc  [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    latch_bank_acc #(.DATA_W(DW), .NUM_CH(NC), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .reset(reset), .data_in(data_in), .ch_sel(ch_sel), .wr_en(wr_en),
        .acc_mode(acc_mode), .clear_all(clear_all), .q_flat(qf[0]), .ovf(ov[0]),
        .dump_start(dump_start), .dump_busy(bsy[0]), .dump_valid(vld[0]),
        .dump_ready(dump_ready), .dump_data(dd[0]), .dump_ch(dc[0]));

    latch_bank_acc #(.DATA_W(DW), .NUM_CH(NC), .SATURATE(1'b1)) u_sat (
        .clk(clk), .reset(reset), .data_in(data_in), .ch_sel(ch_sel), .wr_en(wr_en),
        .acc_mode(acc_mode), .clear_all(clear_all), .q_flat(qf[1]), .ovf(ov[1]),
        .dump_start(dump_start), .dump_busy(bsy[1]), .dump_valid(vld[1]),
        .dump_ready(dump_ready), .dump_data(dd[1]), .dump_ch(dc[1]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: channel values as integers, pending dump beats as a queue (ch*256+data).
    int m_ch  [2][NC];
    int m_ovf [2][NC];
    int mq0 [$];
    int mq1 [$];
    bit m_live = 1'b0;

    function automatic int qsize(input int k);
        return (k == 0) ? mq0.size() : mq1.size();
    endfunction

    function automatic int qfront(input int k);
        return (k == 0) ? mq0[0] : mq1[0];
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                for (int i = 0; i < NC; i++) begin
                    m_ch[k][i]  = 0;
                    m_ovf[k][i] = 0;
                end
                if (k == 0) mq0.delete(); else mq1.delete();
            end else begin
                automatic bit was_busy = (qsize(k) != 0);
                if (was_busy && dump_ready) begin
                    if (k == 0) void'(mq0.pop_front()); else void'(mq1.pop_front());
                end
                if (!was_busy && dump_start) begin
                    for (int i = 0; i < NC; i++) begin
                        if (k == 0) mq0.push_back(i*256 + m_ch[k][i]);
                        else        mq1.push_back(i*256 + m_ch[k][i]);
                    end
                end
                if (clear_all) begin
                    for (int i = 0; i < NC; i++) begin
                        m_ch[k][i]  = 0;
                        m_ovf[k][i] = 0;
                    end
                end else if (wr_en && int'(ch_sel) < NC) begin
                    if (!acc_mode) begin
                        m_ch[k][ch_sel] = int'(data_in);
                    end else begin
                        automatic int s = m_ch[k][ch_sel] + int'(data_in);
                        if (s > 15) begin
                            m_ovf[k][ch_sel] = 1;
                            s = (k == 1) ? 15 : s - 16;
                        end
                        m_ch[k][ch_sel] = s;
                    end
                end
            end
        end
        if (reset) m_live = 1'b1;
    end

    always @(negedge clk) begin
        if (m_live) begin
            for (int k = 0; k < 2; k++) begin
                automatic logic [NC*DW-1:0] eq = '0;
                automatic logic [NC-1:0]    eo = '0;
                automatic string            nm = (k == 0) ? "wrap" : "sat";
                for (int i = 0; i < NC; i++) begin
                    eq[i*DW +: DW] = DW'(m_ch[k][i]);
                    eo[i]          = (m_ovf[k][i] != 0);
                end
                chk({nm, " q_flat"}, 32'(qf[k]), 32'(eq));
                chk({nm, " ovf"}, 32'(ov[k]), 32'(eo));
                chk({nm, " dump_valid"}, 32'(vld[k]), 32'(qsize(k) != 0));
                chk({nm, " dump_busy"}, 32'(bsy[k]), 32'(qsize(k) != 0));
                if (qsize(k) != 0) begin
                    chk({nm, " dump_ch"}, 32'(dc[k]), 32'(qfront(k) / 256));
                    chk({nm, " dump_data"}, 32'(dd[k]), 32'(qfront(k) % 256));
                end
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] c, input logic [3:0] d, input logic acc);
        wr_en = 1'b1; ch_sel = c; data_in = d; acc_mode = acc;
        cyc();
        wr_en = 1'b0; acc_mode = 1'b0;
    endtask

    int beats [8];
    int nb;

    task automatic drain();
        nb = 0;
        for (int c = 0; c < 12 && vld[0]; c++) begin
            if (dump_ready && nb < 8) begin
                beats[nb] = int'(dc[0]) * 256 + int'(dd[0]);
                nb++;
            end
            cyc();
        end
        if (vld[0]) chk("drain timeout", 32'(vld[0]), 32'd0);
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; acc_mode = 1'b0; clear_all = 1'b0;
        dump_start = 1'b0; dump_ready = 1'b0; data_in = '0; ch_sel = '0;
        cyc(); cyc();
        reset = 1'b0;
        chk("reset q_flat", 32'(qf[0]), 32'h0);
        chk("reset dump_data", 32'(dd[0]), 32'h0);
        chk("reset dump_ch", 32'(dc[0]), 32'h0);

        // Load
        wr(2'd0, 4'h3, 1'b0);
        chk("load ch0", 32'(qf[0]), 32'h003);
        wr(2'd1, 4'hA, 1'b0);
        chk("load both", 32'(qf[0]), 32'h0A3);
        chk("load ovf", 32'(ov[0]), 32'h0);

        // Accumulate wrap / saturate on ch0
        wr(2'd0, 4'hE, 1'b0);
        wr(2'd0, 4'h5, 1'b1);
        chk("wrap ch0", 32'(qf[0][3:0]), 32'h3);
        chk("wrap ovf", 32'(ov[0]), 32'h1);
        chk("sat ch0", 32'(qf[1][3:0]), 32'hF);
        wr(2'd0, 4'h1, 1'b1);
        chk("wrap ch0 +1", 32'(qf[0][3:0]), 32'h4);
        chk("wrap ovf sticky", 32'(ov[0]), 32'h1);
        clear_all = 1'b1; cyc(); clear_all = 1'b0;
        chk("clear q", 32'(qf[0]), 32'h0);
        chk("clear ovf", 32'(ov[0]), 32'h0);

        // Saturate on ch1, then clear_all beats a simultaneous write
        wr(2'd1, 4'hC, 1'b0);
        wr(2'd1, 4'h7, 1'b1);
        chk("sat ch1", 32'(qf[1][7:4]), 32'hF);
        chk("sat ovf", 32'(ov[1]), 32'h2);
        chk("wrap ch1", 32'(qf[0][7:4]), 32'h3);
        clear_all = 1'b1; wr_en = 1'b1; ch_sel = 2'd1; data_in = 4'hF;
        cyc();
        clear_all = 1'b0; wr_en = 1'b0;
        chk("clear over wr", 32'(qf[1]), 32'h0);

        // Dump with backpressure
        wr(2'd0, 4'h5, 1'b0);
        wr(2'd1, 4'h9, 1'b0);
        dump_start = 1'b1; cyc(); dump_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("held valid", 32'(vld[0]), 32'h1);
            chk("held beat", {dc[0], dd[0]}, 32'h05);
            cyc();
        end
        dump_ready = 1'b1;
        drain();
        chk("beat count", 32'(nb), 32'd3);
        chk("beat0", 32'(beats[0]), 32'h005);
        chk("beat1", 32'(beats[1]), 32'h109);
        chk("beat2", 32'(beats[2]), 32'h200);
        chk("busy fell", 32'(bsy[0]), 32'h0);

        // Snapshot isolation: same-cycle write and in-dump write/start
        dump_ready = 1'b0;
        dump_start = 1'b1; wr_en = 1'b1; ch_sel = 2'd0; data_in = 4'h7;
        cyc();
        ch_sel = 2'd1; data_in = 4'h2;
        cyc();
        wr_en = 1'b0; dump_start = 1'b0; dump_ready = 1'b1;
        drain();
        chk("iso count", 32'(nb), 32'd3);
        chk("iso beat0", 32'(beats[0]), 32'h005);
        chk("iso beat1", 32'(beats[1]), 32'h109);
        chk("iso live", 32'(qf[0]), 32'h027);
        cyc();
        chk("start not queued", 32'(bsy[0]), 32'h0);

        // Out-of-range channel
        wr(2'd3, 4'hF, 1'b1);
        chk("ch_sel 3 ignored", 32'(qf[0]), 32'h027);
        chk("ch_sel 3 ovf", 32'(ov[0]), 32'h0);

        // Reset mid-dump
        dump_ready = 1'b0; dump_start = 1'b1; cyc(); dump_start = 1'b0;
        chk("pre-reset valid", 32'(vld[0]), 32'h1);
        reset = 1'b1; cyc(); reset = 1'b0;
        chk("abort valid", 32'(vld[0]), 32'h0);
        chk("abort busy", 32'(bsy[0]), 32'h0);
        chk("abort q", 32'(qf[0]), 32'h0);
        dump_ready = 1'b1; cyc();
        chk("no beat after abort", 32'(vld[0]), 32'h0);

        // Random traffic, checked by the per-cycle compare
        for (int n = 0; n < 400; n++) begin
            wr_en      = ($urandom_range(0, 1) == 1);
            acc_mode   = ($urandom_range(0, 1) == 1);
            ch_sel     = 2'($urandom_range(0, 3));
            data_in    = 4'($urandom_range(0, 15));
            clear_all  = ($urandom_range(0, 15) == 0);
            dump_start = ($urandom_range(0, 5) == 0);
            dump_ready = ($urandom_range(0, 2) != 0);
            cyc();
        end
        wr_en = 1'b0; clear_all = 1'b0; dump_start = 1'b0;
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
